// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular instruction buffer between fetch and decode_riscv.
// Holds insn, PC and branch-prediction data; flush empties it in one cycle.
`ifndef M_WIDTH
`define M_WIDTH 64
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 16
`endif
module fetch_decode_queue #(
    parameter int LG_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [31:0]           enq_insn,
    input  logic [`M_WIDTH-1:0]   enq_pc,
    input  logic                  enq_pred,
    input  logic [`LG_PHT_SZ-1:0] enq_pht_idx,
    input  logic [`M_WIDTH-1:0]   enq_pred_target,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic [31:0]           deq_insn,
    output logic [`M_WIDTH-1:0]   deq_pc,
    output logic                  deq_pred,
    output logic [`LG_PHT_SZ-1:0] deq_pht_idx,
    output logic [`M_WIDTH-1:0]   deq_pred_target,
    output logic [LG_DEPTH:0]     occupancy,
    output logic [31:0]           full_stall_cycles
);
    localparam int PW = 32 + 2 * `M_WIDTH + 1 + `LG_PHT_SZ;
    logic [PW-1:0]     mem_q [2**LG_DEPTH];
    logic [LG_DEPTH:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]       stall_q, stall_d;
    logic              empty, full, enq_fire, deq_fire;
    logic [PW-1:0]     head_ent;
    always_comb begin
        empty = head_q == tail_q;
        full = (head_q[LG_DEPTH-1:0] == tail_q[LG_DEPTH-1:0]) && (head_q[LG_DEPTH] != tail_q[LG_DEPTH]);
        enq_ready = !full;
        deq_valid = !empty;
        enq_fire = enq_valid && enq_ready && !flush;
        deq_fire = deq_valid && deq_ready && !flush;
        head_d = flush ? '0 : head_q + {{LG_DEPTH{1'b0}}, deq_fire};
        tail_d = flush ? '0 : tail_q + {{LG_DEPTH{1'b0}}, enq_fire};
        stall_d = (enq_valid && full && !flush && stall_q != '1) ? stall_q + 32'd1 : stall_q;
        occupancy = tail_q - head_q;
        // Empty queue presents all zeros so the decoder sees an illegal opcode.
        head_ent = empty ? '0 : mem_q[head_q[LG_DEPTH-1:0]];
        full_stall_cycles = stall_q;
    end
    assign {deq_insn, deq_pc, deq_pred, deq_pht_idx, deq_pred_target} = head_ent;
    always_ff @(posedge clk) begin
        if (enq_fire) mem_q[tail_q[LG_DEPTH-1:0]] <= {enq_insn, enq_pc, enq_pred, enq_pht_idx, enq_pred_target};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            stall_q <= stall_d;
        end
    end
endmodule
